// File: rtl/uart_rx.sv
// UART receiver: 2-flop synchronized line, mid-bit sampling at CLK_PER_BIT,
// one-cycle data_valid strobe qualified by framing and parity error flags.
module uart_rx #(
    parameter int DATA_BIT_COUNT   = 8,
    parameter int PARITY_BIT_COUNT = 0,
    parameter int PARITY_ODD       = 0,
    parameter int STOP_BIT_COUNT   = 1,
    parameter int CLK_PER_BIT      = 8
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      serial,
    output logic [DATA_BIT_COUNT-1:0] data,
    output logic                      data_valid,
    output logic                      framing_error,
    output logic                      parity_error
);

    localparam int CNT_W = $clog2(CLK_PER_BIT) + 1;
    localparam int IDX_W = 4;
    localparam int HALF  = CLK_PER_BIT / 2;

    localparam logic [CNT_W-1:0] HALF_LAST  = CNT_W'(HALF - 1);
    localparam logic [CNT_W-1:0] BIT_LAST   = CNT_W'(CLK_PER_BIT - 1);
    localparam logic [IDX_W-1:0] DATA_LAST  = IDX_W'(DATA_BIT_COUNT - 1);
    localparam logic [IDX_W-1:0] STOP_DONE  = IDX_W'(STOP_BIT_COUNT);
    localparam bit               HAS_PARITY = (PARITY_BIT_COUNT != 0);
    localparam bit               ODD        = (PARITY_ODD != 0);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } state_e;

    state_e                    state_q, state_d;
    logic                      sync1_q, sync2_q;
    logic                      s;
    logic [CNT_W-1:0]          cnt_q, cnt_d;
    logic [IDX_W-1:0]          idx_q, idx_d;
    logic [DATA_BIT_COUNT-1:0] shift_q, shift_d;
    logic                      parAcc_q, parAcc_d;
    logic                      stopErr_q, stopErr_d;
    logic [DATA_BIT_COUNT-1:0] data_q, data_d;
    logic                      valid_q, valid_d;
    logic                      ferr_q, ferr_d;
    logic                      perr_q, perr_d;

    assign s = sync2_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync1_q   <= 1'b1;
            sync2_q   <= 1'b1;
            state_q   <= IDLE;
            cnt_q     <= '0;
            idx_q     <= '0;
            shift_q   <= '0;
            parAcc_q  <= 1'b0;
            stopErr_q <= 1'b0;
            data_q    <= '0;
            valid_q   <= 1'b0;
            ferr_q    <= 1'b0;
            perr_q    <= 1'b0;
        end else begin
            sync1_q   <= serial;
            sync2_q   <= sync1_q;
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            idx_q     <= idx_d;
            shift_q   <= shift_d;
            parAcc_q  <= parAcc_d;
            stopErr_q <= stopErr_d;
            data_q    <= data_d;
            valid_q   <= valid_d;
            ferr_q    <= ferr_d;
            perr_q    <= perr_d;
        end
    end

    // The stop state lingers one cycle after its last sample so the result
    // is published on the edge that returns to IDLE.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q + CNT_W'(1);
        idx_d     = idx_q;
        shift_d   = shift_q;
        parAcc_d  = parAcc_q;
        stopErr_d = stopErr_q;
        data_d    = data_q;
        valid_d   = 1'b0;
        ferr_d    = 1'b0;
        perr_d    = 1'b0;

        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (!s) begin
                    idx_d     = '0;
                    parAcc_d  = 1'b0;
                    stopErr_d = 1'b0;
                    state_d   = START;
                end
            end
            START: begin
                if (cnt_q == HALF_LAST) begin
                    cnt_d   = '0;
                    state_d = s ? IDLE : DATA;
                end
            end
            DATA: begin
                if (cnt_q == BIT_LAST) begin
                    cnt_d    = '0;
                    shift_d  = {s, shift_q[DATA_BIT_COUNT-1:1]};
                    parAcc_d = parAcc_q ^ s;
                    if (idx_q == DATA_LAST) begin
                        idx_d   = '0;
                        state_d = HAS_PARITY ? PARITY : STOP;
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end
            end
            PARITY: begin
                if (cnt_q == BIT_LAST) begin
                    cnt_d    = '0;
                    parAcc_d = parAcc_q ^ s;
                    state_d  = STOP;
                end
            end
            STOP: begin
                if (idx_q == STOP_DONE) begin
                    cnt_d   = '0;
                    state_d = IDLE;
                    data_d  = shift_q;
                    valid_d = 1'b1;
                    ferr_d  = stopErr_q;
                    perr_d  = HAS_PARITY && (parAcc_q != ODD);
                end else if (cnt_q == BIT_LAST) begin
                    cnt_d = '0;
                    idx_d = idx_q + IDX_W'(1);
                    if (!s) begin
                        stopErr_d = 1'b1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign data          = data_q;
    assign data_valid    = valid_q;
    assign framing_error = ferr_q;
    assign parity_error  = perr_q;

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: four differently configured receivers,
// directed frames from the test plan plus randomized frames against a frame-level model.
module tb_uart_rx;

    localparam int NI = 4;
    localparam int DBITS [NI] = '{8, 8, 8, 5};
    localparam int PBITS [NI] = '{0, 1, 0, 1};
    localparam int PODD  [NI] = '{0, 0, 0, 1};
    localparam int SBITS [NI] = '{1, 1, 2, 2};
    localparam int CPB   [NI] = '{8, 8, 7, 4};

    typedef struct {
        int         inst;
        int         cyc;
        logic [8:0] d;
        logic       fe;
        logic       pe;
    } ev_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic ser0 = 1'b1, ser1 = 1'b1, ser2 = 1'b1, ser3 = 1'b1;
    logic [7:0] d0, d1, d2;
    logic [4:0] d3;
    logic v0, v1, v2, v3;
    logic fe0, fe1, fe2, fe3;
    logic pe0, pe1, pe2, pe3;

    int cyc        = 0;
    int nCompared  = 0;
    int nMismatch  = 0;
    int dblCount   = 0;
    logic [NI-1:0] prevV = '0;
    ev_t obsQ[$];
    ev_t expQ[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    uart_rx #(.DATA_BIT_COUNT(DBITS[0]), .PARITY_BIT_COUNT(PBITS[0]), .PARITY_ODD(PODD[0]),
              .STOP_BIT_COUNT(SBITS[0]), .CLK_PER_BIT(CPB[0])) u0 (
        .clk(clk), .rst_n(rst_n), .serial(ser0), .data(d0), .data_valid(v0),
        .framing_error(fe0), .parity_error(pe0));
    uart_rx #(.DATA_BIT_COUNT(DBITS[1]), .PARITY_BIT_COUNT(PBITS[1]), .PARITY_ODD(PODD[1]),
              .STOP_BIT_COUNT(SBITS[1]), .CLK_PER_BIT(CPB[1])) u1 (
        .clk(clk), .rst_n(rst_n), .serial(ser1), .data(d1), .data_valid(v1),
        .framing_error(fe1), .parity_error(pe1));
    uart_rx #(.DATA_BIT_COUNT(DBITS[2]), .PARITY_BIT_COUNT(PBITS[2]), .PARITY_ODD(PODD[2]),
              .STOP_BIT_COUNT(SBITS[2]), .CLK_PER_BIT(CPB[2])) u2 (
        .clk(clk), .rst_n(rst_n), .serial(ser2), .data(d2), .data_valid(v2),
        .framing_error(fe2), .parity_error(pe2));
    uart_rx #(.DATA_BIT_COUNT(DBITS[3]), .PARITY_BIT_COUNT(PBITS[3]), .PARITY_ODD(PODD[3]),
              .STOP_BIT_COUNT(SBITS[3]), .CLK_PER_BIT(CPB[3])) u3 (
        .clk(clk), .rst_n(rst_n), .serial(ser3), .data(d3), .data_valid(v3),
        .framing_error(fe3), .parity_error(pe3));

    function automatic ev_t mkEv(input int inst, input int c, input logic [8:0] d,
                                 input logic fe, input logic pe);
        ev_t e;
        e.inst = inst;
        e.cyc  = c;
        e.d    = d;
        e.fe   = fe;
        e.pe   = pe;
        return e;
    endfunction

    // Every strobe is logged with the edge count at which it became visible.
    always @(negedge clk) begin
        if (v0) obsQ.push_back(mkEv(0, cyc, {1'b0, d0}, fe0, pe0));
        if (v1) obsQ.push_back(mkEv(1, cyc, {1'b0, d1}, fe1, pe1));
        if (v2) obsQ.push_back(mkEv(2, cyc, {1'b0, d2}, fe2, pe2));
        if (v3) obsQ.push_back(mkEv(3, cyc, {4'b0, d3}, fe3, pe3));
        if ((prevV & {v3, v2, v1, v0}) != '0) dblCount++;
        prevV = {v3, v2, v1, v0};
    end

    task automatic setSer(input int inst, input logic b);
        case (inst)
            0:       ser0 = b;
            1:       ser1 = b;
            2:       ser2 = b;
            default: ser3 = b;
        endcase
    endtask

    task automatic holdBit(input int inst, input logic b, input int n);
        setSer(inst, b);
        repeat (n) @(negedge clk);
    endtask

    // Drives one frame starting at the current negedge and records what the
    // receiver should report: the word, the flags, and the strobe edge
    // T0 + H + N*CLK_PER_BIT + 1 with T0 three edges after the pin falls.
    task automatic sendFrame(input int inst, input logic [8:0] val, input bit badPar,
                             input logic [1:0] stopVals);
        int cpb, nb, n, f;
        logic [8:0] dv;
        logic par, fe, pe;
        cpb = CPB[inst];
        nb  = DBITS[inst];
        dv  = val & 9'((1 << nb) - 1);
        par = (^dv) ^ (PODD[inst] != 0) ^ badPar;
        f   = cyc;
        fe  = 1'b0;
        holdBit(inst, 1'b0, cpb);
        for (int k = 0; k < nb; k++) holdBit(inst, dv[k], cpb);
        if (PBITS[inst] != 0) holdBit(inst, par, cpb);
        for (int s = 0; s < SBITS[inst]; s++) begin
            holdBit(inst, stopVals[s], cpb);
            if (!stopVals[s]) fe = 1'b1;
        end
        pe = (PBITS[inst] != 0) && (((^dv) ^ par) != (PODD[inst] != 0));
        n  = nb + PBITS[inst] + SBITS[inst];
        expQ.push_back(mkEv(inst, f + 3 + cpb / 2 + n * cpb + 1, dv, fe, pe));
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        nCompared++;
        if ({v3, v2, v1, v0} !== 4'b0) begin
            nMismatch++;
            $display("[TB] FAIL reset_valid: got %b expected 0000", {v3, v2, v1, v0});
        end
        nCompared++;
        if ({d0, d1, d2, d3} !== 29'b0) begin
            nMismatch++;
            $display("[TB] FAIL reset_data: got %h expected 0", {d0, d1, d2, d3});
        end
        nCompared++;
        if ({fe3, fe2, fe1, fe0, pe3, pe2, pe1, pe0} !== 8'b0) begin
            nMismatch++;
            $display("[TB] FAIL reset_flags: got %b expected 00000000",
                     {fe3, fe2, fe1, fe0, pe3, pe2, pe1, pe0});
        end
        rst_n = 1'b1;
        repeat (12) @(negedge clk);
        nCompared++;
        if (obsQ.size() !== 0) begin
            nMismatch++;
            $display("[TB] FAIL reset_idle_quiet: got %0d strobes expected 0", obsQ.size());
        end
    endtask

    task automatic test_basic();
        int f;
        obsQ.delete();
        expQ.delete();
        f = cyc;
        sendFrame(0, 9'h0A5, 1'b0, 2'b11);
        holdBit(0, 1'b1, 16);
        nCompared++;
        if (obsQ.size() !== 1) begin
            nMismatch++;
            $display("[TB] FAIL basic_count: got %0d strobes expected 1", obsQ.size());
        end
        if (obsQ.size() >= 1) begin
            nCompared++;
            if (obsQ[0].d !== 9'h0A5) begin
                nMismatch++;
                $display("[TB] FAIL basic_data: got %h expected 0a5", obsQ[0].d);
            end
            nCompared++;
            if (obsQ[0].cyc !== f + 80) begin
                nMismatch++;
                $display("[TB] FAIL basic_latency: got edge %0d expected %0d", obsQ[0].cyc, f + 80);
            end
            nCompared++;
            if ({obsQ[0].fe, obsQ[0].pe} !== 2'b00) begin
                nMismatch++;
                $display("[TB] FAIL basic_flags: got %b expected 00", {obsQ[0].fe, obsQ[0].pe});
            end
        end
    endtask

    task automatic test_glitch();
        obsQ.delete();
        expQ.delete();
        holdBit(0, 1'b0, 2);
        holdBit(0, 1'b1, 20);
        nCompared++;
        if (obsQ.size() !== 0) begin
            nMismatch++;
            $display("[TB] FAIL glitch_reject: got %0d strobes expected 0", obsQ.size());
        end
        sendFrame(0, 9'h03C, 1'b0, 2'b11);
        holdBit(0, 1'b1, 16);
        nCompared++;
        if (obsQ.size() !== 1) begin
            nMismatch++;
            $display("[TB] FAIL glitch_next_count: got %0d strobes expected 1", obsQ.size());
        end
        if (obsQ.size() >= 1) begin
            nCompared++;
            if ({obsQ[0].d, obsQ[0].fe, obsQ[0].pe} !== {9'h03C, 2'b00}) begin
                nMismatch++;
                $display("[TB] FAIL glitch_next_frame: got %h/%b%b expected 03c/00",
                         obsQ[0].d, obsQ[0].fe, obsQ[0].pe);
            end
        end
    endtask

    task automatic test_framing();
        obsQ.delete();
        expQ.delete();
        sendFrame(0, 9'h081, 1'b0, 2'b00);
        holdBit(0, 1'b1, 16);
        sendFrame(0, 9'h05A, 1'b0, 2'b11);
        holdBit(0, 1'b1, 16);
        nCompared++;
        if (obsQ.size() !== 2) begin
            nMismatch++;
            $display("[TB] FAIL framing_count: got %0d strobes expected 2", obsQ.size());
        end
        if (obsQ.size() >= 2) begin
            nCompared++;
            if ({obsQ[0].d, obsQ[0].fe, obsQ[0].pe} !== {9'h081, 2'b10}) begin
                nMismatch++;
                $display("[TB] FAIL framing_error_frame: got %h/%b%b expected 081/10",
                         obsQ[0].d, obsQ[0].fe, obsQ[0].pe);
            end
            nCompared++;
            if ({obsQ[1].d, obsQ[1].fe, obsQ[1].pe} !== {9'h05A, 2'b00}) begin
                nMismatch++;
                $display("[TB] FAIL framing_recover: got %h/%b%b expected 05a/00",
                         obsQ[1].d, obsQ[1].fe, obsQ[1].pe);
            end
        end
    endtask

    task automatic test_parity();
        obsQ.delete();
        expQ.delete();
        sendFrame(1, 9'h007, 1'b0, 2'b11);
        sendFrame(1, 9'h007, 1'b1, 2'b11);
        holdBit(1, 1'b1, 16);
        nCompared++;
        if (obsQ.size() !== 2) begin
            nMismatch++;
            $display("[TB] FAIL parity_count: got %0d strobes expected 2", obsQ.size());
        end
        if (obsQ.size() >= 2) begin
            nCompared++;
            if ({obsQ[0].d, obsQ[0].fe, obsQ[0].pe} !== {9'h007, 2'b00}) begin
                nMismatch++;
                $display("[TB] FAIL parity_good: got %h/%b%b expected 007/00",
                         obsQ[0].d, obsQ[0].fe, obsQ[0].pe);
            end
            nCompared++;
            if ({obsQ[1].d, obsQ[1].fe, obsQ[1].pe} !== {9'h007, 2'b01}) begin
                nMismatch++;
                $display("[TB] FAIL parity_bad: got %h/%b%b expected 007/01",
                         obsQ[1].d, obsQ[1].fe, obsQ[1].pe);
            end
            nCompared++;
            if (obsQ[1].cyc !== expQ[1].cyc) begin
                nMismatch++;
                $display("[TB] FAIL parity_latency: got edge %0d expected %0d", obsQ[1].cyc, expQ[1].cyc);
            end
        end
    endtask

    task automatic test_back_to_back();
        int f;
        obsQ.delete();
        expQ.delete();
        f = cyc;
        sendFrame(2, 9'h000, 1'b0, 2'b11);
        sendFrame(2, 9'h0FF, 1'b0, 2'b11);
        holdBit(2, 1'b1, 20);
        nCompared++;
        if (obsQ.size() !== 2) begin
            nMismatch++;
            $display("[TB] FAIL b2b_count: got %0d strobes expected 2", obsQ.size());
        end
        if (obsQ.size() >= 2) begin
            nCompared++;
            if ({obsQ[0].d, obsQ[0].fe, obsQ[0].pe, obsQ[1].d, obsQ[1].fe, obsQ[1].pe}
                    !== {9'h000, 2'b00, 9'h0FF, 2'b00}) begin
                nMismatch++;
                $display("[TB] FAIL b2b_data: got %h/%b%b %h/%b%b expected 000/00 0ff/00",
                         obsQ[0].d, obsQ[0].fe, obsQ[0].pe, obsQ[1].d, obsQ[1].fe, obsQ[1].pe);
            end
            nCompared++;
            if (obsQ[0].cyc !== f + 77 || obsQ[1].cyc !== f + 154) begin
                nMismatch++;
                $display("[TB] FAIL b2b_timing: got edges %0d,%0d expected %0d,%0d",
                         obsQ[0].cyc, obsQ[1].cyc, f + 77, f + 154);
            end
        end
    endtask

    task automatic test_reset_abort();
        obsQ.delete();
        expQ.delete();
        holdBit(0, 1'b0, 8);
        holdBit(0, 1'b1, 8);
        holdBit(0, 1'b0, 8);
        holdBit(0, 1'b1, 8);
        holdBit(0, 1'b0, 8);
        holdBit(0, 1'b1, 4);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        nCompared++;
        if ({d0, v0, fe0, pe0} !== 11'b0) begin
            nMismatch++;
            $display("[TB] FAIL abort_outputs: got data=%h v=%b fe=%b pe=%b expected all 0",
                     d0, v0, fe0, pe0);
        end
        holdBit(0, 1'b1, 100);
        nCompared++;
        if (obsQ.size() !== 0) begin
            nMismatch++;
            $display("[TB] FAIL abort_no_valid: got %0d strobes expected 0", obsQ.size());
        end
        sendFrame(0, 9'h055, 1'b0, 2'b11);
        holdBit(0, 1'b1, 16);
        nCompared++;
        if (obsQ.size() !== 1) begin
            nMismatch++;
            $display("[TB] FAIL abort_next_count: got %0d strobes expected 1", obsQ.size());
        end
        if (obsQ.size() >= 1) begin
            nCompared++;
            if ({obsQ[0].d, obsQ[0].fe, obsQ[0].pe} !== {9'h055, 2'b00}) begin
                nMismatch++;
                $display("[TB] FAIL abort_next_frame: got %h/%b%b expected 055/00",
                         obsQ[0].d, obsQ[0].fe, obsQ[0].pe);
            end
        end
    endtask

    // Random words, parity faults, stop faults and gaps; a line left low by a
    // bad final stop bit gets at least one bit time of idle before the next start.
    task automatic test_random();
        int gap, nCmp;
        logic [1:0] stopVals;
        for (int inst = 0; inst < NI; inst++) begin
            obsQ.delete();
            expQ.delete();
            for (int fr = 0; fr < 10; fr++) begin
                stopVals = ($urandom_range(0, 3) == 0) ? 2'($urandom) : 2'b11;
                sendFrame(inst, 9'($urandom), ($urandom_range(0, 3) == 0), stopVals);
                if (!stopVals[SBITS[inst] - 1])
                    gap = CPB[inst] + $urandom_range(0, CPB[inst]);
                else if ($urandom_range(0, 1) == 0)
                    gap = 0;
                else
                    gap = $urandom_range(1, 2 * CPB[inst]);
                holdBit(inst, 1'b1, gap);
            end
            holdBit(inst, 1'b1, 3 * CPB[inst]);
            nCompared++;
            if (obsQ.size() !== expQ.size()) begin
                nMismatch++;
                $display("[TB] FAIL random_count[%0d]: got %0d strobes expected %0d",
                         inst, obsQ.size(), expQ.size());
            end
            nCmp = (obsQ.size() < expQ.size()) ? obsQ.size() : expQ.size();
            for (int i = 0; i < nCmp; i++) begin
                nCompared++;
                if (obsQ[i].inst !== expQ[i].inst || obsQ[i].cyc !== expQ[i].cyc) begin
                    nMismatch++;
                    $display("[TB] FAIL random_timing[%0d.%0d]: got u%0d@%0d expected u%0d@%0d",
                             inst, i, obsQ[i].inst, obsQ[i].cyc, expQ[i].inst, expQ[i].cyc);
                end
                nCompared++;
                if ({obsQ[i].d, obsQ[i].fe, obsQ[i].pe} !== {expQ[i].d, expQ[i].fe, expQ[i].pe}) begin
                    nMismatch++;
                    $display("[TB] FAIL random_frame[%0d.%0d]: got %h/%b%b expected %h/%b%b",
                             inst, i, obsQ[i].d, obsQ[i].fe, obsQ[i].pe,
                             expQ[i].d, expQ[i].fe, expQ[i].pe);
                end
            end
        end
    endtask

    task automatic test_pulse_width();
        nCompared++;
        if (dblCount !== 0) begin
            nMismatch++;
            $display("[TB] FAIL pulse_width: got %0d back-to-back strobe cycles expected 0", dblCount);
        end
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_basic();
        test_glitch();
        test_framing();
        test_parity();
        test_back_to_back();
        test_reset_abort();
        test_random();
        test_pulse_width();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatch);
        $finish;
    end

    initial begin
        #2000000;
        nMismatch++;
        $display("[TB] FAIL watchdog: got no completion by %0t expected completion", $time);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatch);
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
